// File: rtl/csr_if.sv
// CSR access port: writeback write stream plus the execute-stage combinational read.
interface csr_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int CSR_ADDR_WIDTH = 12
);
  logic                      csr_we_i;
  logic [CSR_ADDR_WIDTH-1:0] csr_waddr_i;
  logic [DATA_WIDTH-1:0]     csr_wdata_i;
  logic [CSR_ADDR_WIDTH-1:0] csr_raddr_i;
  logic [DATA_WIDTH-1:0]     csr_rdata_o;

  modport master (
    output csr_we_i, csr_waddr_i, csr_wdata_i, csr_raddr_i,
    input  csr_rdata_o
  );

  modport slave (
    input  csr_we_i, csr_waddr_i, csr_wdata_i, csr_raddr_i,
    output csr_rdata_o
  );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file with trap entry / mret handling and optional 64-bit counters.
// Define CSR_COUNTERS_EN to build mcycle/minstret and their user-mode shadows.
module csr_file #(
  parameter int DATA_WIDTH     = 32,
  parameter int CSR_ADDR_WIDTH = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  csr_if.slave                  csr,
  input  logic                  instret_incr_i,
  input  logic                  trap_enter_i,
  input  logic [DATA_WIDTH-1:0] trap_cause_i,
  input  logic [DATA_WIDTH-1:0] trap_epc_i,
  input  logic [DATA_WIDTH-1:0] trap_tval_i,
  input  logic                  mret_i,
  input  logic                  irq_ext_i,
  input  logic                  irq_timer_i,
  input  logic                  irq_soft_i,
  output logic [DATA_WIDTH-1:0] mtvec_o,
  output logic [DATA_WIDTH-1:0] mepc_o,
  output logic [DATA_WIDTH-1:0] mie_o,
  output logic                  mstatus_mie_o
);

  localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MIE      = 12'h304;
  localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MTVEC    = 12'h305;
  localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MEPC     = 12'h341;
  localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MTVAL    = 12'h343;
  localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MIP      = 12'h344;
  localparam logic [DATA_WIDTH-1:0]     MIE_MASK      = 'h888;

  function automatic logic [DATA_WIDTH-1:0] mstatus_pack(input logic mpie, input logic mie);
    return {{(DATA_WIDTH-13){1'b0}}, 2'b11, 3'b000, mpie, 3'b000, mie, 3'b000};
  endfunction

  logic                  mstatus_mie_reg;
  logic                  mstatus_mpie_reg;
  logic [DATA_WIDTH-1:0] mie_reg;
  logic [DATA_WIDTH-1:0] mtvec_reg;
  logic [DATA_WIDTH-1:0] mscratch_reg;
  logic [DATA_WIDTH-1:0] mepc_reg;
  logic [DATA_WIDTH-1:0] mcause_reg;
  logic [DATA_WIDTH-1:0] mtval_reg;

  logic                  wr_hit;
  logic                  sw_we;
  logic [DATA_WIDTH-1:0] wr_value;
  logic [DATA_WIDTH-1:0] stored_rdata;
  logic [DATA_WIDTH-1:0] mip_val;

`ifdef CSR_COUNTERS_EN
  // Counter 0 is mcycle (always counting), counter 1 is minstret.
  logic [1:0] cnt_inc;
  assign cnt_inc = {instret_incr_i, 1'b1};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      localparam logic [CSR_ADDR_WIDTH-1:0] LO_ADDR = 12'hB00 + 12'(2 * gi);
      localparam logic [CSR_ADDR_WIDTH-1:0] HI_ADDR = 12'hB80 + 12'(2 * gi);
      logic [63:0] cnt_reg;

      // A write to either half freezes the other half for that cycle.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          cnt_reg <= '0;
        end else if (csr.csr_we_i && csr.csr_waddr_i == LO_ADDR) begin
          cnt_reg[31:0] <= csr.csr_wdata_i;
        end else if (csr.csr_we_i && csr.csr_waddr_i == HI_ADDR) begin
          cnt_reg[63:32] <= csr.csr_wdata_i;
        end else if (cnt_inc[gi]) begin
          cnt_reg <= cnt_reg + 64'd1;
        end
      end
    end
  endgenerate
`else
  logic unused_instret;
  assign unused_instret = instret_incr_i;
`endif

  assign mip_val = {{(DATA_WIDTH-12){1'b0}}, irq_ext_i, 3'b000, irq_timer_i, 3'b000,
                    irq_soft_i, 3'b000};

  // Masked value a software write would commit; shared by storage and read bypass.
  always_comb begin
    wr_hit   = 1'b1;
    wr_value = csr.csr_wdata_i;
    case (csr.csr_waddr_i)
      ADDR_MSTATUS:             wr_value = mstatus_pack(csr.csr_wdata_i[7], csr.csr_wdata_i[3]);
      ADDR_MIE:                 wr_value = csr.csr_wdata_i & MIE_MASK;
      ADDR_MTVEC, ADDR_MEPC:    wr_value = {csr.csr_wdata_i[DATA_WIDTH-1:2], 2'b00};
      ADDR_MSCRATCH, ADDR_MCAUSE, ADDR_MTVAL: wr_value = csr.csr_wdata_i;
`ifdef CSR_COUNTERS_EN
      12'hB00, 12'hB80, 12'hB02, 12'hB82:   wr_value = csr.csr_wdata_i;
`endif
      default:                  wr_hit = 1'b0;
    endcase
  end

  assign sw_we = csr.csr_we_i & wr_hit;

  always_comb begin
    stored_rdata = '0;
    case (csr.csr_raddr_i)
      ADDR_MSTATUS:  stored_rdata = mstatus_pack(mstatus_mpie_reg, mstatus_mie_reg);
      ADDR_MIE:      stored_rdata = mie_reg;
      ADDR_MTVEC:    stored_rdata = mtvec_reg;
      ADDR_MSCRATCH: stored_rdata = mscratch_reg;
      ADDR_MEPC:     stored_rdata = mepc_reg;
      ADDR_MCAUSE:   stored_rdata = mcause_reg;
      ADDR_MTVAL:    stored_rdata = mtval_reg;
      ADDR_MIP:      stored_rdata = mip_val;
`ifdef CSR_COUNTERS_EN
      12'hB00, 12'hC00: stored_rdata = g_cnt[0].cnt_reg[31:0];
      12'hB80, 12'hC80: stored_rdata = g_cnt[0].cnt_reg[63:32];
      12'hB02, 12'hC02: stored_rdata = g_cnt[1].cnt_reg[31:0];
      12'hB82, 12'hC82: stored_rdata = g_cnt[1].cnt_reg[63:32];
`endif
      default:       stored_rdata = '0;
    endcase
  end

  assign csr.csr_rdata_o = (sw_we && csr.csr_waddr_i == csr.csr_raddr_i) ? wr_value : stored_rdata;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mstatus_mie_reg  <= 1'b0;
      mstatus_mpie_reg <= 1'b0;
      mie_reg          <= '0;
      mtvec_reg        <= '0;
      mscratch_reg     <= '0;
      mepc_reg         <= '0;
      mcause_reg       <= '0;
      mtval_reg        <= '0;
    end else begin
      // Trap/mret own mstatus, mepc, mcause and mtval for the cycle they fire.
      if (trap_enter_i) begin
        mepc_reg         <= {trap_epc_i[DATA_WIDTH-1:2], 2'b00};
        mcause_reg       <= trap_cause_i;
        mtval_reg        <= trap_tval_i;
        mstatus_mpie_reg <= mstatus_mie_reg;
        mstatus_mie_reg  <= 1'b0;
      end else if (mret_i) begin
        mstatus_mie_reg  <= mstatus_mpie_reg;
        mstatus_mpie_reg <= 1'b1;
      end else if (sw_we) begin
        case (csr.csr_waddr_i)
          ADDR_MSTATUS: begin
            mstatus_mie_reg  <= wr_value[3];
            mstatus_mpie_reg <= wr_value[7];
          end
          ADDR_MEPC:   mepc_reg   <= wr_value;
          ADDR_MCAUSE: mcause_reg <= wr_value;
          ADDR_MTVAL:  mtval_reg  <= wr_value;
          default: ;
        endcase
      end

      if (sw_we) begin
        case (csr.csr_waddr_i)
          ADDR_MIE:      mie_reg      <= wr_value;
          ADDR_MTVEC:    mtvec_reg    <= wr_value;
          ADDR_MSCRATCH: mscratch_reg <= wr_value;
          default: ;
        endcase
      end
    end
  end

  assign mtvec_o       = mtvec_reg;
  assign mepc_o        = mepc_reg;
  assign mie_o         = mie_reg;
  assign mstatus_mie_o = mstatus_mie_reg;

endmodule
